// File: rtl/air_hockey_pkg.sv
// Shared air-hockey definitions: game state encoding, screen geometry and ball size,
// common to the collision, motion and render stages.
package air_hockey_pkg;

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        PLAY      = 2'd1,
        GAME_OVER = 2'd2
    } game_state_t;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int BALL_W    = 8;
    localparam int BALL_H    = 8;

    // Top-left coordinate that centres an object of 'size' pixels within 'extent'.
    function automatic logic [15:0] centreOf(input int extent, input int size);
        return 16'((extent - size) / 2);
    endfunction

endpackage

// File: rtl/axis_step.sv
// One-axis ball step: moves pos by +/-speed and saturates the result to [LO, HI].
// Subtraction is done in 17 bits so a step past zero clamps instead of wrapping.
module axis_step #(
    parameter int LO = 0,
    parameter int HI = 632
) (
    input  logic [15:0] pos,
    input  logic [7:0]  speed,
    input  logic        dir,
    output logic [15:0] next
);

    function automatic logic [15:0] satAdd(input logic [15:0] a, input logic [7:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {9'd0, b};
        return (sum > 17'(HI)) ? 16'(HI) : sum[15:0];
    endfunction

    // diff[16] set means the subtraction went below zero.
    function automatic logic [15:0] satSub(input logic [15:0] a, input logic [7:0] b);
        logic [16:0] diff;
        diff = {1'b0, a} - {9'd0, b};
        return (diff[16] || (diff < 17'(LO))) ? 16'(LO) : diff[15:0];
    endfunction

    always_comb begin
        next = dir ? satAdd(pos, speed) : satSub(pos, speed);
    end

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball kinematics and rally/score controller for air hockey.
// Optional build macro BALL_MOTION_SPEEDUP_EN: paddle hits raise ballXSpeed up to MAX_SPEED.
module ball_motion
    import air_hockey_pkg::*;
#(
    parameter int H_VISIBLE    = air_hockey_pkg::H_VISIBLE,
    parameter int V_VISIBLE    = air_hockey_pkg::V_VISIBLE,
    parameter int BALL_W       = air_hockey_pkg::BALL_W,
    parameter int BALL_H       = air_hockey_pkg::BALL_H,
    parameter int START_SPEED  = 2,
    parameter int MAX_SPEED    = 8,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic        pixelClock,
    input  logic        reset,
    input  logic        vSyncStart,
    input  logic        collisionBallScreenLeft,
    input  logic        collisionBallScreenRight,
    input  logic        collisionBallScreenTop,
    input  logic        collisionBallScreenBottom,
    input  logic        collisionBallPlayerPaddle,
    input  logic        collisionBallComputerPaddle,
    input  logic        startButton,
    output logic [15:0] ballX,
    output logic [15:0] ballY,
    output logic [7:0]  ballXSpeed,
    output logic [7:0]  ballYSpeed,
    output logic        ballXDir,
    output logic        ballYDir,
    output logic [3:0]  playerScore,
    output logic [3:0]  computerScore,
    output logic [1:0]  gameState,
    output logic        scoreEvent
);

    localparam int X_MAX = H_VISIBLE - BALL_W;
    localparam int Y_MAX = V_VISIBLE - BALL_H;
    localparam logic [15:0] X_CENTRE = centreOf(H_VISIBLE, BALL_W);
    localparam logic [15:0] Y_CENTRE = centreOf(V_VISIBLE, BALL_H);
    // A serve never starts faster than the ceiling.
    localparam logic [7:0] SERVE_SPEED = 8'((START_SPEED > MAX_SPEED) ? MAX_SPEED : START_SPEED);
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    game_state_t state, stateNext;
    logic             frameTick;
    logic [CNT_W-1:0] serveCount, serveCountNext;
    logic [15:0]      ballXNext, ballYNext, stepX, stepY;
    logic [7:0]       ballXSpeedNext, ballYSpeedNext;
    logic             ballXDirNext, ballYDirNext, playXDir, playYDir;
    logic [3:0]       playerScoreNext, computerScoreNext;
    logic             scoreEventNext;

`ifdef BALL_MOTION_SPEEDUP_EN
    function automatic logic [7:0] speedUp(input logic [7:0] s);
        return (s >= 8'(MAX_SPEED)) ? 8'(MAX_SPEED) : s + 8'd1;
    endfunction
`endif

    // Collision flags settle on vSyncStart; state acts one cycle later.
    always_ff @(posedge pixelClock) begin
        if (reset) frameTick <= 1'b0;
        else       frameTick <= vSyncStart;
    end

    // A paddle flag wins over its same-side wall so a saved ball is not scored.
    always_comb begin
        playXDir = ballXDir;
        if (collisionBallPlayerPaddle)        playXDir = 1'b1;
        else if (collisionBallComputerPaddle) playXDir = 1'b0;
        else if (collisionBallScreenLeft)     playXDir = 1'b1;
        else if (collisionBallScreenRight)    playXDir = 1'b0;
        playYDir = ballYDir;
        if (collisionBallScreenTop)           playYDir = 1'b1;
        else if (collisionBallScreenBottom)   playYDir = 1'b0;
    end

    axis_step #(.LO(0), .HI(X_MAX)) stepXInst (
        .pos(ballX), .speed(ballXSpeed), .dir(playXDir), .next(stepX)
    );

    axis_step #(.LO(0), .HI(Y_MAX)) stepYInst (
        .pos(ballY), .speed(ballYSpeed), .dir(playYDir), .next(stepY)
    );

    always_comb begin
        stateNext         = state;
        serveCountNext    = serveCount;
        ballXNext         = ballX;
        ballYNext         = ballY;
        ballXSpeedNext    = ballXSpeed;
        ballYSpeedNext    = ballYSpeed;
        ballXDirNext      = ballXDir;
        ballYDirNext      = ballYDir;
        playerScoreNext   = playerScore;
        computerScoreNext = computerScore;
        scoreEventNext    = 1'b0;

        if (frameTick) begin
            unique case (state)
                SERVE: begin
                    ballXNext      = X_CENTRE;
                    ballYNext      = Y_CENTRE;
                    ballXSpeedNext = SERVE_SPEED;
                    ballYSpeedNext = SERVE_SPEED;
                    if (serveCount == CNT_W'(SERVE_FRAMES - 1)) begin
                        serveCountNext = '0;
                        stateNext      = PLAY;
                    end else begin
                        serveCountNext = serveCount + 1'b1;
                    end
                end

                PLAY: begin
                    ballXDirNext = playXDir;
                    ballYDirNext = playYDir;
                    if (!collisionBallPlayerPaddle && !collisionBallComputerPaddle &&
                        (collisionBallScreenLeft || collisionBallScreenRight)) begin
                        if (collisionBallScreenLeft) computerScoreNext = computerScore + 4'd1;
                        else                         playerScoreNext   = playerScore + 4'd1;
                        scoreEventNext = 1'b1;
                        ballXNext      = X_CENTRE;
                        ballYNext      = Y_CENTRE;
                        ballXSpeedNext = SERVE_SPEED;
                        ballYSpeedNext = SERVE_SPEED;
                        serveCountNext = '0;
                        if ((computerScoreNext == 4'(WIN_SCORE)) || (playerScoreNext == 4'(WIN_SCORE)))
                            stateNext = GAME_OVER;
                        else
                            stateNext = SERVE;
                    end else begin
`ifdef BALL_MOTION_SPEEDUP_EN
                        if (collisionBallPlayerPaddle || collisionBallComputerPaddle)
                            ballXSpeedNext = speedUp(ballXSpeed);
`endif
                        ballXNext = stepX;
                        ballYNext = stepY;
                    end
                end

                GAME_OVER: begin
                    if (startButton) begin
                        playerScoreNext   = 4'd0;
                        computerScoreNext = 4'd0;
                        serveCountNext    = '0;
                        stateNext         = SERVE;
                    end
                end

                default: stateNext = SERVE;
            endcase
        end
    end

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            state         <= SERVE;
            serveCount    <= '0;
            ballX         <= X_CENTRE;
            ballY         <= Y_CENTRE;
            ballXSpeed    <= SERVE_SPEED;
            ballYSpeed    <= SERVE_SPEED;
            ballXDir      <= 1'b0;
            ballYDir      <= 1'b1;
            playerScore   <= 4'd0;
            computerScore <= 4'd0;
            scoreEvent    <= 1'b0;
        end else begin
            state         <= stateNext;
            serveCount    <= serveCountNext;
            ballX         <= ballXNext;
            ballY         <= ballYNext;
            ballXSpeed    <= ballXSpeedNext;
            ballYSpeed    <= ballYSpeedNext;
            ballXDir      <= ballXDirNext;
            ballYDir      <= ballYDirNext;
            playerScore   <= playerScoreNext;
            computerScore <= computerScoreNext;
            scoreEvent    <= scoreEventNext;
        end
    end

    assign gameState = state;

endmodule
